// File: rtl/fetch_decode_pipe.sv
// Two-stage RV32I-subset front end: PC/fetch, IF/ID register, decode into ID/EX register.
// Latency: instruction at imem_addr=p appears on the ID/EX outputs two rising edges later.
// stall holds PC and IF/ID and bubbles ID/EX; redirect (wins over stall) reloads PC and flushes both stages.
module fetch_decode_pipe #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int ALU_CTRL_W    = 3,
  parameter logic [DATA_WIDTH-1:0] PC_RESET = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [DATA_WIDTH-1:0]    redirect_pc,
  output logic [DATA_WIDTH-1:0]    imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     id_valid,
  output logic                     RegWrite,
  output logic [ALU_CTRL_W-1:0]    ALUctrl,
  output logic                     ALUsrc,
  output logic                     MemWrite,
  output logic [1:0]               ResultSrc,
  output logic                     Branch,
  output logic                     Jump,
  output logic [2:0]               funct3,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic [DATA_WIDTH-1:0]    id_pc,
  output logic                     illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = ALU_CTRL_W'(7);

  // Shared funct3 -> ALU op table; sltu folds onto slt and sra onto srl.
  function automatic logic [ALU_CTRL_W-1:0] alu_sel(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_sel = ALU_ADD;
      3'b001:  alu_sel = ALU_SLL;
      3'b010:  alu_sel = ALU_SLT;
      3'b011:  alu_sel = ALU_SLT;
      3'b100:  alu_sel = ALU_XOR;
      3'b101:  alu_sel = ALU_SRL;
      3'b110:  alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] ifid_instr;
  logic [DATA_WIDTH-1:0] ifid_pc;
  logic                  ifid_valid;

  assign imem_addr = pc;

  // PC: redirect target (word aligned) beats stall; otherwise advance by one word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= PC_RESET;
    end else if (redirect) begin
      pc <= redirect_pc & ~DATA_WIDTH'(3);
    end else if (!stall) begin
      pc <= pc + DATA_WIDTH'(4);
    end
  end

  // IF/ID: capture fetched word; a redirect kills the slot, a stall freezes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_instr <= '0;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
    end else if (redirect) begin
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_instr <= imem_rdata;
      ifid_pc    <= pc;
      ifid_valid <= 1'b1;
    end
  end

  logic [6:0]               opcode;
  logic                     d_legal;
  logic                     d_regwrite;
  logic [ALU_CTRL_W-1:0]    d_aluctrl;
  logic                     d_alusrc;
  logic                     d_memwrite;
  logic [1:0]               d_resultsrc;
  logic                     d_branch;
  logic                     d_jump;
  logic [ADDRESS_WIDTH-1:0] d_rs1;
  logic [DATA_WIDTH-1:0]    d_imm;
  logic [DATA_WIDTH-1:0]    imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = ifid_instr[6:0];
  assign imm_i  = {{(DATA_WIDTH-12){ifid_instr[31]}}, ifid_instr[31:20]};
  assign imm_s  = {{(DATA_WIDTH-12){ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
  assign imm_b  = {{(DATA_WIDTH-13){ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                   ifid_instr[30:25], ifid_instr[11:8], 1'b0};
  assign imm_u  = {{(DATA_WIDTH-32){ifid_instr[31]}}, ifid_instr[31:12], 12'b0};
  assign imm_j  = {{(DATA_WIDTH-21){ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                   ifid_instr[20], ifid_instr[30:21], 1'b0};

  // Decode the IF/ID word into execute controls and the selected immediate.
  always_comb begin
    d_legal     = 1'b1;
    d_regwrite  = 1'b0;
    d_aluctrl   = ALU_ADD;
    d_alusrc    = 1'b0;
    d_memwrite  = 1'b0;
    d_resultsrc = 2'b00;
    d_branch    = 1'b0;
    d_jump      = 1'b0;
    d_rs1       = ADDRESS_WIDTH'(ifid_instr[19:15]);
    d_imm       = '0;
    case (opcode)
      OP_R: begin
        d_regwrite = 1'b1;
        d_aluctrl  = (ifid_instr[14:12] == 3'b000 && ifid_instr[30]) ? ALU_SUB
                                                                    : alu_sel(ifid_instr[14:12]);
      end
      OP_I_ALU: begin
        d_regwrite = 1'b1;
        d_alusrc   = 1'b1;
        d_aluctrl  = alu_sel(ifid_instr[14:12]);
        d_imm      = imm_i;
      end
      OP_LOAD: begin
        d_regwrite  = 1'b1;
        d_alusrc    = 1'b1;
        d_resultsrc = 2'b01;
        d_imm       = imm_i;
      end
      OP_STORE: begin
        d_memwrite = 1'b1;
        d_alusrc   = 1'b1;
        d_imm      = imm_s;
      end
      OP_BRANCH: begin
        d_branch  = 1'b1;
        d_aluctrl = ALU_SUB;
        d_imm     = imm_b;
      end
      OP_LUI: begin
        d_regwrite = 1'b1;
        d_alusrc   = 1'b1;
        d_rs1      = '0;
        d_imm      = imm_u;
      end
      OP_JAL: begin
        d_regwrite  = 1'b1;
        d_jump      = 1'b1;
        d_resultsrc = 2'b10;
        d_imm       = imm_j;
      end
      OP_JALR: begin
        d_regwrite  = 1'b1;
        d_jump      = 1'b1;
        d_alusrc    = 1'b1;
        d_resultsrc = 2'b10;
        d_imm       = imm_i;
      end
      default: d_legal = 1'b0;
    endcase
  end

  logic advance;
  assign advance = ifid_valid && !stall && !redirect;

  // ID/EX: load decoded instruction, or an all-zero bubble; illegal pulses only when the slot would have advanced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid  <= 1'b0;
      RegWrite  <= 1'b0;
      ALUctrl   <= '0;
      ALUsrc    <= 1'b0;
      MemWrite  <= 1'b0;
      ResultSrc <= 2'b00;
      Branch    <= 1'b0;
      Jump      <= 1'b0;
      funct3    <= 3'b000;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      ImmOp     <= '0;
      id_pc     <= '0;
      illegal   <= 1'b0;
    end else if (advance && d_legal) begin
      id_valid  <= 1'b1;
      RegWrite  <= d_regwrite;
      ALUctrl   <= d_aluctrl;
      ALUsrc    <= d_alusrc;
      MemWrite  <= d_memwrite;
      ResultSrc <= d_resultsrc;
      Branch    <= d_branch;
      Jump      <= d_jump;
      funct3    <= ifid_instr[14:12];
      rs1       <= d_rs1;
      rs2       <= ADDRESS_WIDTH'(ifid_instr[24:20]);
      rd        <= ADDRESS_WIDTH'(ifid_instr[11:7]);
      ImmOp     <= d_imm;
      id_pc     <= ifid_pc;
      illegal   <= 1'b0;
    end else begin
      id_valid  <= 1'b0;
      RegWrite  <= 1'b0;
      ALUctrl   <= '0;
      ALUsrc    <= 1'b0;
      MemWrite  <= 1'b0;
      ResultSrc <= 2'b00;
      Branch    <= 1'b0;
      Jump      <= 1'b0;
      funct3    <= 3'b000;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      ImmOp     <= '0;
      id_pc     <= '0;
      illegal   <= advance && !d_legal;
    end
  end

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Bench for fetch_decode_pipe: directed reset/decode/stall/redirect/wrap checks plus a random program.
// Expected decoded instructions are queued by the stimulus thread and consumed by a monitor on negedge.
// Random stall and redirect exercise hold, flush and ordering of the instruction stream.
module tb_fetch_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid, RegWrite, ALUsrc, MemWrite, Branch, Jump, illegal;
  logic [2:0]  ALUctrl, funct3;
  logic [1:0]  ResultSrc;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] ImmOp, id_pc;

  fetch_decode_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .id_valid(id_valid), .RegWrite(RegWrite),
    .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
    .Branch(Branch), .Jump(Jump), .funct3(funct3), .rs1(rs1), .rs2(rs2), .rd(rd),
    .ImmOp(ImmOp), .id_pc(id_pc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  assign imem_rdata = mem[imem_addr[7:2]];

  typedef struct packed {
    logic        ill;
    logic        rw;
    logic [2:0]  alu;
    logic        src;
    logic        mw;
    logic [1:0]  res;
    logic        br;
    logic        jp;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: architectural fetch PC and the one fetched-but-undecoded word.
  logic [31:0] m_pc;
  logic        m_pend_v;
  logic [31:0] m_pend_pc;

  function automatic logic [2:0] alu_of(input logic [2:0] f3);
    case (f3)
      3'd0: return 3'b000;
      3'd1: return 3'b110;
      3'd2: return 3'b101;
      3'd3: return 3'b101;
      3'd4: return 3'b100;
      3'd5: return 3'b111;
      3'd6: return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [31:0] sgn_i, imm_i, imm_s, imm_b, imm_j;
    e = '0;
    sgn_i = ins[31] ? 32'hFFFF_F800 : 32'h0;
    imm_i = sgn_i + 32'(ins[30:20]);
    imm_s = sgn_i + 32'(ins[30:25]) * 32 + 32'(ins[11:7]);
    imm_b = (ins[31] ? 32'hFFFF_F000 : 32'h0) + 32'(ins[7]) * 2048
            + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
    imm_j = (ins[31] ? 32'hFFF0_0000 : 32'h0) + 32'(ins[19:12]) * 4096
            + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
    e.f3 = ins[14:12]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.pc = pc;
    case (ins[6:0])
      7'h33: begin e.rw = 1; e.alu = (ins[14:12] == 0 && ins[30]) ? 3'b001 : alu_of(ins[14:12]); end
      7'h13: begin e.rw = 1; e.src = 1; e.alu = alu_of(ins[14:12]); e.imm = imm_i; end
      7'h03: begin e.rw = 1; e.src = 1; e.res = 2'b01; e.imm = imm_i; end
      7'h23: begin e.mw = 1; e.src = 1; e.imm = imm_s; end
      7'h63: begin e.br = 1; e.alu = 3'b001; e.imm = imm_b; end
      7'h37: begin e.rw = 1; e.src = 1; e.rs1 = 0; e.imm = ins & 32'hFFFF_F000; end
      7'h6F: begin e.rw = 1; e.jp = 1; e.res = 2'b10; e.imm = imm_j; end
      7'h67: begin e.rw = 1; e.jp = 1; e.src = 1; e.res = 2'b10; e.imm = imm_i; end
      default: begin e = '0; e.ill = 1; end
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", nm, got, want);
    end
  endtask

  // Apply one cycle of control inputs, advance the model, then step past the edge.
  task automatic step(input logic s, input logic r, input logic [31:0] t);
    stall = s; redirect = r; redirect_pc = t;
    if (r) begin
      m_pend_v = 0;
      m_pc = {t[31:2], 2'b00};
    end else if (!s) begin
      if (m_pend_v) exp_q.push_back(ref_decode(mem[m_pend_pc[7:2]], m_pend_pc));
      m_pend_v = 1; m_pend_pc = m_pc; m_pc = m_pc + 32'd4;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    case ($urandom_range(0, 9))
      0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h23;
      4: op = 7'h63; 5: op = 7'h37; 6: op = 7'h6F; 7: op = 7'h67;
      8: op = 7'h7F; default: op = 7'h0B;
    endcase
    return {r[31:7], op};
  endfunction

  // Monitor: every presented instruction or illegal pulse must match the queue head; bubbles carry no controls.
  always @(negedge clk) begin
    if (!rst) begin
      if (id_valid || illegal) begin
        exp_t e, got;
        tests++;
        got = {illegal, RegWrite, ALUctrl, ALUsrc, MemWrite, ResultSrc, Branch, Jump,
               funct3, rs1, rs2, rd, ImmOp, id_pc};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output got=%h valid=%b", got, id_valid);
        end else begin
          e = exp_q.pop_front();
          if (e.ill ? !(illegal === 1'b1 && id_valid === 1'b0)
                    : !(got === e && id_valid === 1'b1)) begin
            fails++;
            $display("FAIL stream got=%h valid=%b expected=%h", got, id_valid, e);
          end
        end
      end else begin
        tests++;
        if ({RegWrite, MemWrite, Branch, Jump} !== 4'b0000) begin
          fails++;
          $display("FAIL bubble_ctrl got=%b expected=0000", {RegWrite, MemWrite, Branch, Jump});
        end
      end
    end
  end

  logic [31:0] held;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = rand_instr();
    mem[0]  = 32'h0050_0093;
    mem[1]  = 32'hFE20_8CE3;
    mem[63] = 32'h0000_007F;
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    m_pc = 0; m_pend_v = 0; m_pend_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", {31'd0, id_valid}, 0);
    chk("rst_imm", ImmOp, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_illegal", {31'd0, illegal}, 0);
    rst = 0;

    // Run a few cycles then assert reset between edges.
    repeat (5) step(0, 0, 0);
    rst = 1;
    #1;
    chk("arst_addr", imem_addr, 0);
    chk("arst_valid", {31'd0, id_valid}, 0);
    chk("arst_regwrite", {31'd0, RegWrite}, 0);
    exp_q.delete();
    m_pc = 0; m_pend_v = 0;
    @(posedge clk); #1;
    rst = 0;

    // addi x1,x0,5 then beq x1,x2,-8
    step(0, 0, 0);
    step(0, 0, 0);
    chk("addi_valid", {31'd0, id_valid}, 1);
    chk("addi_rd", {27'd0, rd}, 1);
    chk("addi_rs1", {27'd0, rs1}, 0);
    chk("addi_imm", ImmOp, 5);
    chk("addi_alusrc", {31'd0, ALUsrc}, 1);
    chk("addi_regwrite", {31'd0, RegWrite}, 1);
    chk("addi_aluctrl", {29'd0, ALUctrl}, 0);
    chk("addi_pc", id_pc, 0);
    step(0, 0, 0);
    chk("beq_branch", {31'd0, Branch}, 1);
    chk("beq_regwrite", {31'd0, RegWrite}, 0);
    chk("beq_rs1", {27'd0, rs1}, 1);
    chk("beq_rs2", {27'd0, rs2}, 2);
    chk("beq_imm", ImmOp, 32'hFFFF_FFF8);
    chk("beq_funct3", {29'd0, funct3}, 0);

    // Two stall cycles: fetch address frozen, bubbles on ID/EX.
    held = imem_addr;
    step(1, 0, 0);
    chk("stall1_addr", imem_addr, held);
    chk("stall1_valid", {31'd0, id_valid}, 0);
    step(1, 0, 0);
    chk("stall2_addr", imem_addr, held);
    chk("stall2_valid", {31'd0, id_valid}, 0);
    repeat (3) step(0, 0, 0);

    // Redirect together with stall: redirect wins, target aligned, two empty slots.
    step(1, 1, 32'h0000_0103);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    chk("redir_valid1", {31'd0, id_valid}, 0);
    step(0, 0, 0);
    chk("redir_valid2", {31'd0, id_valid}, 0);
    step(0, 0, 0);

    // Illegal opcode at the top word, then PC wraps to 0.
    step(0, 1, 32'hFFFF_FFFC);
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("wrap_zero", imem_addr, 0);
    step(0, 0, 0);
    chk("illegal_pulse", {31'd0, illegal}, 1);
    chk("illegal_valid", {31'd0, id_valid}, 0);
    step(0, 0, 0);
    chk("illegal_clear", {31'd0, illegal}, 0);

    // Random program with random stalls and redirects.
    for (int n = 0; n < 600; n++) begin
      int roll;
      roll = $urandom_range(0, 99);
      if (roll < 8) step($urandom_range(0, 1) == 1, 1, $urandom_range(0, 255));
      else if (roll < 28) step(1, 0, 0);
      else step(0, 0, 0);
    end
    step(0, 0, 0);
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
